// File: rtl/serial_addsub_pkg.sv
// Shared types and elaboration helpers for the chunked serial adder/subtractor.
package serial_addsub_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Legal geometry: at least two bits, and the slice must tile the word exactly.
  function automatic bit geometry_ok(input int width, input int chunk);
    return (width >= 2) && (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Operand/result channel of serial_addsub; the producer/consumer side is master.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// sender holds its payload stable until that edge, ready may toggle freely.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, x, y, sub, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, x, y, sub, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, zero
  );
endinterface

// File: rtl/serial_addsub_chunk_adder.sv
// CHUNK-bit ripple-carry slice; the only arithmetic in serial_addsub.
module chunk_adder #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle two's-complement add/subtract, CHUNK bits per clock, LSB first.
// Subtraction is A + ~B + 1, so carry_out=1 means "no borrow".
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_addsub_if.slave bus,
  output state_t        dbg_state
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (!geometry_ok(WIDTH, CHUNK)) begin : g_bad_geometry
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, sh_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               msba_q, msbb_q;
  logic [WIDTH-1:0]   result_q;
  logic               cout_q, ovf_q, zero_q;
  logic               in_ready_c, out_valid_c;

  logic [WIDTH-1:0]       b_in;
  logic [CHUNK-1:0]       sum;
  logic                   cout;
  logic [WIDTH+CHUNK-1:0] cat;
  logic [WIDTH-1:0]       sh_next;
  logic                   last;

  assign b_in    = bus.sub ? ~bus.y : bus.y;
  // New sum bits enter at the MSB end while the partial result slides right.
  assign cat     = {sum, sh_q};
  assign sh_next = cat[WIDTH+CHUNK-1:CHUNK];
  assign last    = (cnt_q == CNT_W'(N - 1));

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a    (a_q[CHUNK-1:0]),
    .b    (b_q[CHUNK-1:0]),
    .cin  (carry_q),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      msba_q   <= 1'b0;
      msbb_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.x;
            b_q     <= b_in;
            sh_q    <= '0;
            carry_q <= bus.sub;
            cnt_q   <= '0;
            msba_q  <= bus.x[WIDTH-1];
            msbb_q  <= b_in[WIDTH-1];
          end
        end
        RUN: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          sh_q    <= sh_next;
          carry_q <= cout;
          cnt_q   <= cnt_q + 1'b1;
          // Output fields only change once the whole word is known.
          if (last) begin
            result_q <= sh_next;
            cout_q   <= cout;
            ovf_q    <= (msba_q == msbb_q) && (sh_next[WIDTH-1] != msba_q);
            zero_q   <= (sh_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.result    = result_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: four WIDTH=8 instances (CHUNK 1,2,4,8) behind a selector.
module tb_serial_addsub;
  import serial_addsub_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] x = '0;
  logic [7:0] y = '0;
  logic       sub = 1'b0;
  logic       out_ready = 1'b0;
  int         sel = 0;

  logic       ir_a [4];
  logic       ov_a [4];
  logic [7:0] res_a [4];
  logic       co_a [4];
  logic       of_a [4];
  logic       z_a [4];
  state_t     st_a [4];

  logic       o_in_ready, o_out_valid, o_carry, o_ovf, o_zero;
  logic [7:0] o_result;
  state_t     o_state;
  logic [10:0] o_pack;

  logic [10:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_addsub_if #(.WIDTH(8)) bus();
    state_t st;
    assign bus.in_valid  = in_valid && (sel == g);
    assign bus.x         = x;
    assign bus.y         = y;
    assign bus.sub       = sub;
    assign bus.out_ready = out_ready && (sel == g);
    serial_addsub #(.WIDTH(8), .CHUNK(1 << g)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (st)
    );
    assign ir_a[g]  = bus.in_ready;
    assign ov_a[g]  = bus.out_valid;
    assign res_a[g] = bus.result;
    assign co_a[g]  = bus.carry_out;
    assign of_a[g]  = bus.overflow;
    assign z_a[g]   = bus.zero;
    assign st_a[g]  = st;
  end

  always_comb begin
    o_in_ready  = ir_a[sel];
    o_out_valid = ov_a[sel];
    o_result    = res_a[sel];
    o_carry     = co_a[sel];
    o_ovf       = of_a[sel];
    o_zero      = z_a[sel];
    o_state     = st_a[sel];
    o_pack      = {o_carry, o_ovf, o_zero, o_result};
  end

  // Reference: integer arithmetic, independent of the bit-serial datapath.
  function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
    int ua, ub, sa, sb, r, sr;
    logic c, ovf;
    logic [7:0] res;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      r  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub;
      c  = (r > 255);
      sr = sa + sb;
    end
    res = 8'(r & 255);
    ovf = (sr > 127) || (sr < -128);
    return {c, ovf, (res == 8'h00), res};
  endfunction

  task automatic drive_op(input logic [7:0] a, input logic [7:0] b, input logic s);
    int t;
    t = 0;
    while (!o_in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!o_in_ready) begin
      checks++;
      failures++;
      $display("FAIL drive_timeout: in_ready=%0b required 1", o_in_ready);
      return;
    end
    x = a; y = b; sub = s; in_valid = 1'b1;
    exp_q.push_back(model(a, b, s));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!o_out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!o_out_valid) begin
      checks++;
      failures++;
      $display("FAIL out_timeout: out_valid=%0b required 1", o_out_valid);
    end
  endtask

  task automatic test_reset();
    sel = 0;
    checks++;
    if (o_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0b exp 1", o_in_ready); end
    checks++;
    if (o_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b exp 0", o_out_valid); end
    checks++;
    if (o_pack !== 11'h000) begin failures++; $display("FAIL reset_fields: got %h exp 000", o_pack); end
    checks++;
    if (o_state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d exp %0d", o_state, IDLE); end
  endtask

  task automatic test_add_basic();
    int lat;
    logic [10:0] e;
    sel = 0;
    out_ready = 1'b1;
    drive_op(8'h05, 8'h03, 1'b0);
    wait_out(lat);
    checks++;
    if (lat !== 8) begin failures++; $display("FAIL basic_latency: got %0d exp 8", lat); end
    e = exp_q.pop_front();
    checks++;
    if (o_pack !== e || e !== {1'b0, 1'b0, 1'b0, 8'h08}) begin
      failures++; $display("FAIL basic_fields: got %h exp %h", o_pack, e);
    end
    @(posedge clk); #1;
    checks++;
    if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
      failures++; $display("FAIL basic_one_shot: out_valid=%0b in_ready=%0b exp 0/1", o_out_valid, o_in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int lat;
    logic [10:0] e;
    sel = 0;
    out_ready = 1'b1;
    drive_op(8'hFF, 8'h01, 1'b0);
    wait_out(lat);
    e = exp_q.pop_front();
    checks++;
    if (o_pack !== e || e !== {1'b1, 1'b0, 1'b1, 8'h00}) begin
      failures++; $display("FAIL wrap_ff_01: got %h exp %h", o_pack, e);
    end
    @(posedge clk); #1;
    drive_op(8'h7F, 8'h01, 1'b0);
    wait_out(lat);
    e = exp_q.pop_front();
    checks++;
    if (o_pack !== e || e !== {1'b0, 1'b1, 1'b0, 8'h80}) begin
      failures++; $display("FAIL wrap_7f_01: got %h exp %h", o_pack, e);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_chunk4_sub();
    int lat;
    logic [10:0] e;
    sel = 2;
    out_ready = 1'b1;
    drive_op(8'h10, 8'h10, 1'b1);
    wait_out(lat);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL c4_latency: got %0d exp 2", lat); end
    e = exp_q.pop_front();
    checks++;
    if (o_pack !== e || e !== {1'b1, 1'b0, 1'b1, 8'h00}) begin
      failures++; $display("FAIL c4_sub_equal: got %h exp %h", o_pack, e);
    end
    @(posedge clk); #1;
    drive_op(8'h80, 8'h01, 1'b1);
    wait_out(lat);
    e = exp_q.pop_front();
    checks++;
    if (o_pack !== e || e !== {1'b1, 1'b1, 1'b0, 8'h7F}) begin
      failures++; $display("FAIL c4_sub_ovf: got %h exp %h", o_pack, e);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    sel = 0;
  endtask

  task automatic test_backpressure();
    int lat;
    logic [10:0] snap, e;
    sel = 0;
    out_ready = 1'b0;
    drive_op(8'h12, 8'h34, 1'b0);
    wait_out(lat);
    snap = o_pack;
    for (int i = 0; i < 5; i++) begin
      x = 8'hAA; y = 8'h55; sub = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (o_pack !== snap || o_out_valid !== 1'b1 || o_in_ready !== 1'b0 || o_state !== DONE) begin
        failures++;
        $display("FAIL bp_hold: fields=%h ov=%0b ir=%0b st=%0d exp %h/1/0/%0d", o_pack, o_out_valid, o_in_ready, o_state, snap, DONE);
      end
    end
    in_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (snap !== e) begin failures++; $display("FAIL bp_result: got %h exp %h", snap, e); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || o_pack !== e) begin
      failures++; $display("FAIL bp_release: ov=%0b ir=%0b fields=%h exp 0/1/%h", o_out_valid, o_in_ready, o_pack, e);
    end
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (o_out_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++; $display("FAIL bp_ignored_ops: out_valid=%0b pending=%0d exp 0/0", o_out_valid, exp_q.size());
    end
  endtask

  task automatic test_reset_midop();
    int lat;
    logic [10:0] e;
    sel = 0;
    out_ready = 1'b1;
    drive_op(8'h44, 8'h11, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || o_pack !== 11'h000 || o_state !== IDLE) begin
      failures++;
      $display("FAIL midop_reset: ov=%0b ir=%0b fields=%h st=%0d exp 0/1/000/%0d", o_out_valid, o_in_ready, o_pack, o_state, IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive_op(8'h21, 8'h12, 1'b0);
    wait_out(lat);
    e = exp_q.pop_front();
    checks++;
    if (o_pack !== e || e[7:0] !== 8'h33) begin
      failures++; $display("FAIL midop_recover: got %h exp %h", o_pack, e);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int lat, stall;
    logic [10:0] e;
    for (int i = 0; i < 1000; i++) begin
      sel = i % 4;
      out_ready = 1'b0;
      drive_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      wait_out(lat);
      checks++;
      if (lat != (8 >> sel)) begin failures++; $display("FAIL rand_latency[%0d]: got %0d exp %0d", i, lat, 8 >> sel); end
      stall = $urandom_range(0, 3);
      repeat (stall) @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (o_out_valid !== 1'b1 || o_pack !== e) begin
        failures++; $display("FAIL rand_result[%0d]: ov=%0b got %h exp %h (x=%h y=%h sub=%0b chunk=%0d)", i, o_out_valid, o_pack, e, x, y, sub, 1 << sel);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_add_basic();
    test_wrap();
    test_chunk4_sub();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Multi-cycle, parametrised two's-complement adder/subtractor. Processes CHUNK bits per clock, LSB chunk first, over WIDTH/CHUNK cycles.
- Successor to the fixed 5-bit combinational ripple adder. Adds width/chunk generality, subtract mode, status flags and valid/ready handshakes on input and output.
- Sits between an operand producer and a result consumer in the datapath exercises. Trades latency for a CHUNK-bit adder slice.

Parameters:
- WIDTH, 8: operand and result width in bits. Must be ≥2 and a multiple of CHUNK.
- CHUNK, 1: bits summed per cycle, i.e. the width of the adder slice.
- N (localparam), WIDTH/CHUNK: number of RUN cycles.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands x, y, sub present
- in_ready  out  1  block can accept operands
- x  in  WIDTH  operand A
- y  in  WIDTH  operand B
- sub  in  1  0: A+B, 1: A−B
- out_valid  out  1  result fields valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  sum/difference, modulo 2^WIDTH
- carry_out  out  1  carry out of MSB (in sub mode 1 = no borrow)
- overflow  out  1  signed overflow
- zero  out  1  result == 0

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. Asserting it clears all state immediately.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, carry_out=0, overflow=0, zero=0. Internal count, operand and carry registers are 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at a rising edge, capture A=x and B=(sub ? ~y : y), carry=sub, count=0. Store msbA=x[WIDTH-1] and msbB=B[WIDTH-1]. Go to RUN.
  - Without in_valid, remain in IDLE.
- RUN:
  - in_ready=0. in_valid is ignored.
  - Each edge, the chunk_adder sums A[CHUNK-1:0], B[CHUNK-1:0] and carry.
  - The CHUNK sum bits shift into the result register from the MSB end. Result shifts right by CHUNK.
  - A and B shift right by CHUNK. carry takes the chunk carry-out. count increments.
  - On the edge where count==N-1, the final chunk is processed and the FSM goes to DONE.
- DONE:
  - out_valid=1. result, carry_out (= final carry), overflow and zero are stable while out_valid=1 and out_ready=0.
  - overflow = (msbA==msbB) && (result[WIDTH-1]!=msbA).
  - zero = (result==0).
  - On an edge with out_ready=1, go to IDLE and drop out_valid. Result fields hold their last values.
- Latency: operands accepted at edge 0. out_valid rises after edge N, exactly N cycles after acceptance.
- Throughput: one operation per N+2 cycles minimum. No input acceptance in the DONE→IDLE handoff cycle. in_ready is a pure function of state.
- Boundary cases:
  - out_ready held high before DONE: the result is consumed one cycle after out_valid rises. out_valid is high for exactly one cycle.
  - CHUNK==WIDTH: N=1, single RUN cycle.
  - Wrap-around: result is modulo 2^WIDTH; carry_out is the bit that wraps off.
  - Subtract of equal operands: result=0, zero=1, carry_out=1, overflow=0.
  - Reset asserted in RUN or DONE: the operation is aborted with no output. After release, the block is in IDLE with in_ready=1.
  - x/y/sub changes while not in IDLE have no effect.

Decomposition:
- Shared package serial_addsub_pkg:
  - state enum {IDLE, RUN, DONE}
  - state width constant
  - elaboration-time check that WIDTH%CHUNK==0
- Sub-module chunk_adder #(CHUNK):
  - Purely combinational CHUNK-bit ripple chain of full adders.
  - Ports: a, b, cin, sum, cout.
  - Instantiated once. This is the only combinational arithmetic in the block.

Test Plan:
- WIDTH=8, CHUNK=1: x=0x05, y=0x03, sub=0. Expect out_valid exactly 8 cycles after acceptance, result=0x08, carry_out=0, overflow=0, zero=0.
- WIDTH=8, CHUNK=1: x=0xFF, y=0x01, sub=0. Expect result=0x00, carry_out=1, zero=1, overflow=0. Then x=0x7F, y=0x01 → result=0x80, overflow=1, carry_out=0.
- WIDTH=8, CHUNK=4: x=0x10, y=0x10, sub=1 → result=0x00, zero=1, carry_out=1, latency 2 cycles. Then x=0x80, y=0x01, sub=1 → result=0x7F, overflow=1.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE. Expect fields stable and in_ready=0. Assert in_valid with new operands meanwhile; they must be ignored. Release out_ready → IDLE next cycle, in_ready=1.
- Reset mid-op: drop rst_n asynchronously (between edges) in RUN cycle 3. Expect out_valid=0, in_ready=1 and all outputs 0 immediately. Next accepted operation 0x21+0x12 → 0x33, correct.
- Random: 1000 random x/y/sub at WIDTH=8 with CHUNK 1, 2, 4, 8 and random out_ready stalls. Compare against a behavioural model: {carry_out,result} = x ± y; overflow and zero as defined above.
